dual_edge_moore: RTL and testbench
==================================

Name: dual_edge_moore

Overview:
Moore-style dual-edge detector. Samples a single-bit level input (per channel) on each rising clock edge. Emits a one-clock pulse on `anyEdge` whenever a rising or falling transition is sampled. Sits between slow/level sources (switches, pre-synchronised pins, handshake lines) and logic needing single-cycle event strobes; N independent channels share one clock and reset.

Parameters:
N_CH, 1, number of independent channels; each channel has its own 4-state FSM.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
sig  input  N_CH  level inputs; bit i feeds channel i.
anyEdge  output  N_CH  registered-state-decoded edge pulse; bit i high for one cycle per sampled edge on sig[i].

Behaviour:
- One clock; synchronous reset, active-low (name `reset`, asserted when 0).
- Per-channel state register, 2 bits, four states:
  - ZERO: level low, idle.
  - RISE: rising edge just sampled.
  - ONE: level high, idle.
  - FALL: falling edge just sampled.
- Transitions, evaluated at rising clk when reset=1, using the sampled s = sig[i]:
  - ZERO: s=1 -> RISE; else stay ZERO.
  - RISE: s=1 -> ONE; s=0 -> FALL.
  - ONE: s=0 -> FALL; else stay ONE.
  - FALL: s=0 -> ZERO; s=1 -> RISE.
- Output is Moore: anyEdge[i] = 1 iff state is RISE or FALL. Decoded from the state register only, so glitch-free and with no combinational path from sig.
- Latency:
  - sig change sampled at posedge k -> anyEdge high from posedge k to posedge k+1.
  - Exactly one cycle if sig is stable at k+1.
- Back-to-back edges on consecutive samples (RISE->FALL or FALL->RISE) hold anyEdge high continuously, one cycle per edge.
- Transitions of sig that both occur between two consecutive posedges are invisible: no pulse, state unchanged.
- Reset:
  - When reset=0 at a posedge, every channel goes to ZERO and anyEdge=0 from that edge.
  - Reset takes priority over any simultaneous sig change.
  - Reset mid-pulse truncates the pulse.
- After reset release with sig=1, the first sample produces a RISE pulse. Reset state is ZERO by definition.
- Before the first reset, state is undefined; no power-on initialisation is required.
- Channels are fully independent; no cross-channel interaction.

Optional Feature:
DUAL_EDGE_SYNC_EN:
- Defined: each sig bit passes through a 2-flop synchroniser before the FSM.
  - Synchroniser flops reset to 0 on reset=0.
  - Edge-to-pulse latency grows by 2 cycles: change before posedge k gives a pulse from k+2 to k+3.
  - sig may be asynchronous.
- Undefined: sig feeds the FSM directly. sig must be synchronous to clk, meeting setup/hold.

Test Plan:
- Clock period 8 ns. Hold reset=0 for 1 posedge, then release; sig=0 -> anyEdge stays 0 for 5 cycles, state ZERO.
- sig 0->1 mid-cycle, held 3 cycles -> anyEdge=1 for exactly one cycle after the next posedge; then 0 (state ONE). With DUAL_EDGE_SYNC_EN the pulse comes 2 cycles later.
- sig 1->0 held -> single one-cycle pulse; consecutive-sample toggles 0->1->0 (8 ns apart) -> anyEdge high 2 consecutive cycles (RISE then FALL), then 0.
- sig pulses high for 1-2 ns between posedges (0->1->0 or three toggles netting a change) -> no pulse for the net-zero case; exactly one pulse when the net level changed.
- sig changes coincident with a posedge (setup met) -> pulse at that edge; reset=0 asserted while anyEdge=1 -> anyEdge=0 after that edge and no pulse resumes.
- N_CH=4: edges on channels 0 and 2 in the same cycle, channel 1 steady high -> anyEdge=4'b0101 for one cycle; channel 1 produces no pulse.

Source files
------------

// File: rtl/dual_edge_moore.sv
// dual_edge_moore: per-channel Moore FSM that turns every sampled rising
// or falling transition of a level input into a one-clock strobe.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   reset    synchronous active-low reset (0 = reset)
//   sig      level inputs, bit i feeds channel i
//   anyEdge  edge strobe, bit i high for one cycle per sampled edge of sig[i]
//
// Optional build macro:
//   DUAL_EDGE_SYNC_EN  inserts a 2-flop synchroniser per channel ahead of
//                      the FSM so sig may be asynchronous to clk; this adds
//                      two cycles of edge-to-pulse latency.

module dual_edge_moore #(
    parameter int N_CH = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sig,
    output logic [N_CH-1:0] anyEdge
);

    // RISE/FALL share bit 0 so the pulse decode is a single bit per channel.
    typedef enum logic [1:0] {
        ZERO = 2'b00,
        RISE = 2'b01,
        ONE  = 2'b10,
        FALL = 2'b11
    } state_t;

    logic [N_CH-1:0] s;

`ifdef DUAL_EDGE_SYNC_EN
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sig;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = sig;
`endif

    state_t state [N_CH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (!reset) begin
                state[i] <= ZERO;
            end else begin
                unique case (state[i])
                    ZERO: state[i] <= s[i] ? RISE : ZERO;
                    RISE: state[i] <= s[i] ? ONE  : FALL;
                    ONE:  state[i] <= s[i] ? ONE  : FALL;
                    FALL: state[i] <= s[i] ? RISE : ZERO;
                endcase
            end
        end
    end

    // Pure decode of the state register: no path from sig to anyEdge.
    always_comb begin
        anyEdge = '0;
        for (int i = 0; i < N_CH; i++) begin
            anyEdge[i] = (state[i] == RISE) || (state[i] == FALL);
        end
    end

endmodule

// File: tb/tb_dual_edge_moore.sv
// tb_dual_edge_moore: directed stimulus for dual_edge_moore with a
// sampled-level reference model feeding an expected-result queue.

module tb_dual_edge_moore;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] sig;
    logic [N-1:0] anyEdge;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_q [$];
    logic [N-1:0] prev = '0;
    logic [N-1:0] p1 = '0;
    logic [N-1:0] p2 = '0;

    dual_edge_moore #(.N_CH(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .sig     (sig),
        .anyEdge (anyEdge)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Reference: a pulse follows any sample that differs from the previous
    // sample as seen by the FSM; reset forgets the history (level low).
    task automatic sample(input string tag);
        logic [N-1:0] fin;
        logic [N-1:0] e;
        @(posedge clk);
        if (!reset) begin
            prev = '0;
            p1   = '0;
            p2   = '0;
            e    = '0;
        end else begin
`ifdef DUAL_EDGE_SYNC_EN
            fin = p2;
            p2  = p1;
            p1  = sig;
`else
            fin = sig;
`endif
            e    = fin ^ prev;
            prev = fin;
        end
        exp_q.push_back(e);
        #1;
        checks++;
        e = exp_q.pop_front();
        assert (anyEdge === e) else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, anyEdge, e);
        end
    endtask

    task automatic drv(input logic r, input logic [N-1:0] v,
                       input string tag);
        @(negedge clk);
        reset = r;
        sig   = v;
        sample(tag);
    endtask

    task automatic glitch(input logic [N-1:0] v1, input logic [N-1:0] v2,
                          input logic [N-1:0] v3, input string tag);
        @(negedge clk);
        sig = v1;
        #1 sig = v2;
        #1 sig = v3;
        sample(tag);
    endtask

    task automatic late(input logic [N-1:0] v, input string tag);
        @(negedge clk);
        #3 sig = v;
        sample(tag);
    endtask

    initial begin
        reset = 1'b0;
        sig   = '0;

        drv(1'b0, 4'b0000, "reset");
        for (int i = 0; i < 5; i++) drv(1'b1, 4'b0000, "idle_low");

        drv(1'b1, 4'b0001, "rise");
        drv(1'b1, 4'b0001, "rise_hold1");
        drv(1'b1, 4'b0001, "rise_hold2");
        drv(1'b1, 4'b0000, "fall");
        drv(1'b1, 4'b0000, "fall_hold1");
        drv(1'b1, 4'b0000, "fall_hold2");

        drv(1'b1, 4'b0001, "b2b_rise");
        drv(1'b1, 4'b0000, "b2b_fall");
        drv(1'b1, 4'b0000, "b2b_after");
        drv(1'b1, 4'b0000, "b2b_after2");

        glitch(4'b0001, 4'b0000, 4'b0000, "glitch_net0");
        drv(1'b1, 4'b0000, "glitch_net0_b");
        glitch(4'b0001, 4'b0000, 4'b0001, "glitch_net1");
        drv(1'b1, 4'b0001, "glitch_net1_b");
        drv(1'b1, 4'b0001, "glitch_net1_c");
        glitch(4'b0000, 4'b0001, 4'b0001, "glitch_hi_net0");
        drv(1'b1, 4'b0001, "glitch_hi_net0_b");

        late(4'b0000, "late_fall");
        drv(1'b1, 4'b0000, "late_fall_b");
        drv(1'b1, 4'b0000, "late_fall_c");

        drv(1'b1, 4'b0001, "pre_rst_pulse");
        drv(1'b0, 4'b0000, "rst_trunc");
        drv(1'b1, 4'b0000, "rst_release0");
        for (int i = 0; i < 3; i++) drv(1'b1, 4'b0000, "rst_no_resume");

        drv(1'b0, 4'b0001, "rst_prio");
        drv(1'b1, 4'b0001, "release_high");
        for (int i = 0; i < 3; i++) drv(1'b1, 4'b0001, "release_high_b");

        drv(1'b1, 4'b0010, "ch1_only");
        for (int i = 0; i < 3; i++) drv(1'b1, 4'b0010, "ch1_hold");
        drv(1'b1, 4'b0111, "ch02_edges");
        for (int i = 0; i < 3; i++) drv(1'b1, 4'b0111, "ch02_after");
        drv(1'b1, 4'b1010, "mixed");
        for (int i = 0; i < 3; i++) drv(1'b1, 4'b1010, "mixed_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
